i2c_master: RTL and testbench

Single-master I2C bus controller that runs one complete transaction per command: START, 7-bit address plus R/W, 1–4 data bytes, STOP. It sits on the host side of the scoreboard/ranking I2C link and drives the address-0x55 ranking/FND slave. It also works with any slave that samples SDA on SCL rising and does not clock-stretch. A host FSM or CPU-mapped register block issues commands on a start/busy/done handshake.

---
 rtl/i2c_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-master I2C controller. Each accepted command runs one
// complete START / address+R/W / 1-4 data bytes / STOP transaction.
// SCL is push-pull; SDA is open-drain and is only ever pulled low.
module i2c_master #(
  parameter int CLK_DIV = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [6:0]  slv_addr,
  input  logic [1:0]  num_bytes,
  input  logic [31:0] tx_data,
  output logic [31:0] rx_data,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic        SCL,
  inout  wire         SDA
);

  localparam logic [15:0] DIV_LOAD = 16'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, STOP
  } state_t;

  state_t      r_state, w_state;
  logic [1:0]  r_qtr, w_qtr;
  logic [2:0]  r_bitCnt, w_bitCnt;
  logic [1:0]  r_byteCnt, w_byteCnt;
  logic        r_rw, w_rw;
  logic [1:0]  r_numBytes, w_numBytes;
  logic [31:0] r_txData, w_txData;
  logic [7:0]  r_shift, w_shift;
  logic        r_ackBit, w_ackBit;
  logic [31:0] r_rxData, w_rxData;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_ackErr, w_ackErr;
  logic [15:0] r_divCnt;
  logic        w_tick;
  logic        w_scl;
  logic        w_sdaLow;
  logic        w_sdaIn;

  assign w_tick  = r_busy && (r_divCnt == 16'd0);
  assign w_sdaIn = SDA;
  assign SCL     = w_scl;
  assign SDA     = w_sdaLow ? 1'b0 : 1'bz;
  assign rx_data = r_rxData;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ackErr;

  // Quarter-period divider: held at its load value while idle, so the first tick lands CLK_DIV cycles after acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_divCnt <= DIV_LOAD;
    end else if (!r_busy || r_divCnt == 16'd0) begin
      r_divCnt <= DIV_LOAD;
    end else begin
      r_divCnt <= r_divCnt - 16'd1;
    end
  end

  // State and datapath registers, all advanced from the next-state logic below
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_qtr      <= 2'd0;
      r_bitCnt   <= 3'd0;
      r_byteCnt  <= 2'd0;
      r_rw       <= 1'b0;
      r_numBytes <= 2'd0;
      r_txData   <= 32'd0;
      r_shift    <= 8'd0;
      r_ackBit   <= 1'b0;
      r_rxData   <= 32'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ackErr   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_qtr      <= w_qtr;
      r_bitCnt   <= w_bitCnt;
      r_byteCnt  <= w_byteCnt;
      r_rw       <= w_rw;
      r_numBytes <= w_numBytes;
      r_txData   <= w_txData;
      r_shift    <= w_shift;
      r_ackBit   <= w_ackBit;
      r_rxData   <= w_rxData;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_ackErr   <= w_ackErr;
    end
  end

  // Next-state logic: everything except command acceptance moves only on a quarter tick
  always_comb begin
    w_state    = r_state;
    w_qtr      = r_qtr;
    w_bitCnt   = r_bitCnt;
    w_byteCnt  = r_byteCnt;
    w_rw       = r_rw;
    w_numBytes = r_numBytes;
    w_txData   = r_txData;
    w_shift    = r_shift;
    w_ackBit   = r_ackBit;
    w_rxData   = r_rxData;
    w_busy     = r_busy;
    w_done     = 1'b0;
    w_ackErr   = r_ackErr;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state    = START;
          w_qtr      = 2'd0;
          w_bitCnt   = 3'd0;
          w_byteCnt  = 2'd0;
          w_rw       = rw;
          w_numBytes = num_bytes;
          w_txData   = tx_data;
          w_shift    = {slv_addr, rw};
          w_rxData   = 32'd0;
          w_ackErr   = 1'b0;
          w_busy     = 1'b1;
        end
      end
      START: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd1) begin
            w_state = ADDR;
            w_qtr   = 2'd0;
          end
        end
      end
      ADDR, WR_BYTE: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            w_bitCnt = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              w_state = (r_state == ADDR) ? ADDR_ACK : WR_ACK;
            end else begin
              w_shift = {r_shift[6:0], 1'b0};
            end
          end
        end
      end
      ADDR_ACK, WR_ACK: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd2) begin
            w_ackBit = w_sdaIn;
          end
          if (r_qtr == 2'd3) begin
            if (r_ackBit) begin
              w_ackErr = 1'b1;
              w_state  = STOP;
            end else if (r_state == ADDR_ACK && r_rw) begin
              w_state = RD_BYTE;
            end else if (r_state == WR_ACK && r_byteCnt == r_numBytes) begin
              w_state = STOP;
            end else begin
              w_state  = WR_BYTE;
              w_shift  = r_txData[31:24];
              w_txData = {r_txData[23:0], 8'h00};
              if (r_state == WR_ACK) begin
                w_byteCnt = r_byteCnt + 2'd1;
              end
            end
          end
        end
      end
      RD_BYTE: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd2) begin
            w_shift = {r_shift[6:0], w_sdaIn};
          end
          if (r_qtr == 2'd3) begin
            w_bitCnt = r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              w_state = RD_ACK;
              case (r_byteCnt)
                2'd0:    w_rxData[31:24] = r_shift;
                2'd1:    w_rxData[23:16] = r_shift;
                2'd2:    w_rxData[15:8]  = r_shift;
                default: w_rxData[7:0]   = r_shift;
              endcase
            end
          end
        end
      end
      RD_ACK: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd3) begin
            if (r_byteCnt == r_numBytes) begin
              w_state = STOP;
            end else begin
              w_state   = RD_BYTE;
              w_byteCnt = r_byteCnt + 2'd1;
            end
          end
        end
      end
      STOP: begin
        if (w_tick) begin
          w_qtr = r_qtr + 2'd1;
          if (r_qtr == 2'd2) begin
            w_state = IDLE;
            w_qtr   = 2'd0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
          end
        end
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // Bus levels decoded from state and quarter; SCL is high in Q2/Q3 of every bit frame
  always_comb begin
    w_scl    = 1'b1;
    w_sdaLow = 1'b0;
    case (r_state)
      START: begin
        w_scl    = (r_qtr == 2'd0);
        w_sdaLow = 1'b1;
      end
      ADDR, WR_BYTE: begin
        w_scl    = r_qtr[1];
        w_sdaLow = ~r_shift[7];
      end
      ADDR_ACK, WR_ACK, RD_BYTE: begin
        w_scl = r_qtr[1];
      end
      RD_ACK: begin
        w_scl    = r_qtr[1];
        w_sdaLow = (r_byteCnt != r_numBytes);
      end
      STOP: begin
        w_scl    = (r_qtr != 2'd0);
        w_sdaLow = (r_qtr != 2'd2);
      end
      default: begin
        w_scl    = 1'b1;
        w_sdaLow = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: randomized and directed transactions against a bus-model
// slave at 0x55, compared with a byte-level reference of the transaction.
module tb_i2c_master;

  localparam int         CLK_DIV    = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h55;
  localparam int         WAIT_LIMIT = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rw;
  logic [6:0]  slv_addr;
  logic [1:0]  num_bytes;
  logic [31:0] tx_data;
  logic [31:0] rx_data;
  logic        busy;
  logic        done;
  logic        ack_err;
  logic        SCL;
  wire         SDA;

  logic        slvLow = 1'b0;
  assign SDA = slvLow ? 1'b0 : 1'bz;
  pullup (SDA);

  // slave model state (owned by the monitor process)
  logic        prevScl = 1'b1;
  logic        prevSda = 1'b1;
  logic        sclNow, sdaNow;
  int          rises = 0;
  int          frame = 0;
  logic        addrHit = 1'b0;
  logic        rdMode = 1'b0;
  logic        driving = 1'b0;
  logic        lastAck = 1'b1;
  logic [7:0]  shiftIn = 8'd0;
  logic [7:0]  curByte = 8'd0;
  logic [63:0] traceBits = 64'd0;
  int          traceLen = 0;
  int          startCnt = 0;
  int          stopCnt = 0;

  // slave configuration (owned by the stimulus process)
  int          cfgNackByte;
  logic [31:0] cfgRdData;

  // reference results
  logic [63:0] expTrace;
  int          expLen;
  logic        expErr;
  logic [31:0] expRx;
  int          expQuarters;

  int          compareCount = 0;
  int          mismatchCount = 0;

  logic        rndRw;
  logic [6:0]  rndAddr;
  logic [1:0]  rndNb;
  int          rndNack;

  i2c_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .slv_addr(slv_addr),
    .num_bytes(num_bytes), .tx_data(tx_data), .rx_data(rx_data), .busy(busy),
    .done(done), .ack_err(ack_err), .SCL(SCL), .SDA(SDA)
  );

  always #5 clk = ~clk;

  // Bus monitor and slave: samples the bus every cycle, decodes START/STOP/bits, drives ACKs and read data
  always @(negedge clk) begin
    if (!reset) begin
      slvLow  = 1'b0;
      prevScl = 1'b1;
      prevSda = 1'b1;
    end else begin
      sclNow = SCL;
      sdaNow = (SDA === 1'b0) ? 1'b0 : 1'b1;
      if (prevScl && sclNow && prevSda && !sdaNow) begin
        startCnt++;
        rises = 0; frame = 0; driving = 1'b0; slvLow = 1'b0;
        traceBits = 64'd0; traceLen = 0;
      end else if (prevScl && sclNow && !prevSda && sdaNow) begin
        stopCnt++;
        slvLow = 1'b0;
      end else if (!prevScl && sclNow) begin
        traceBits = {traceBits[62:0], sdaNow};
        traceLen++;
        rises++;
        if (rises <= 8) shiftIn = {shiftIn[6:0], sdaNow};
        if (rises == 9) lastAck = sdaNow;
      end else if (prevScl && !sclNow && rises > 0) begin
        if (rises == 8) begin
          driving = 1'b0;
          if (frame == 0) begin
            addrHit = (shiftIn[7:1] == SLAVE_ADDR);
            rdMode  = shiftIn[0];
            slvLow  = addrHit;
          end else if (!rdMode) begin
            slvLow = (frame - 1 != cfgNackByte);
          end else begin
            slvLow = 1'b0;
          end
        end else if (rises == 9) begin
          rises   = 0;
          driving = (frame == 0) ? (addrHit && rdMode) : (rdMode && !lastAck);
          frame++;
          if (driving && frame <= 4) begin
            curByte = cfgRdData[31 - 8*(frame-1) -: 8];
            slvLow  = !curByte[7];
          end else begin
            driving = 1'b0;
            slvLow  = 1'b0;
          end
        end else if (driving && rises < 8) begin
          slvLow = !curByte[7 - rises];
        end
      end
      prevScl = sclNow;
      prevSda = sdaNow;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic pushBit(input logic v);
    expTrace = {expTrace[62:0], v};
    expLen++;
  endtask

  // Byte-level reference: bits seen on SCL rises, final ack_err/rx_data and transaction length in quarters
  task automatic modelTransaction(input logic rwv, input logic [6:0] addr, input logic [1:0] nb,
                                  input logic [31:0] tx, input int nackByte, input logic [31:0] rdData);
    logic [7:0] b;
    expTrace = 64'd0; expLen = 0; expErr = 1'b0; expRx = 32'd0;
    expQuarters = 2 + 36 + 3;
    b = {addr, rwv};
    for (int i = 7; i >= 0; i--) pushBit(b[i]);
    if (addr != SLAVE_ADDR) begin
      pushBit(1'b1);
      expErr = 1'b1;
    end else begin
      pushBit(1'b0);
      for (int k = 0; k <= int'(nb); k++) begin
        expQuarters += 36;
        if (rwv) begin
          b = rdData[31 - 8*k -: 8];
          for (int i = 7; i >= 0; i--) pushBit(b[i]);
          expRx[31 - 8*k -: 8] = b;
          pushBit(k == int'(nb));
        end else begin
          b = tx[31 - 8*k -: 8];
          for (int i = 7; i >= 0; i--) pushBit(b[i]);
          if (k == nackByte) begin
            pushBit(1'b1);
            expErr = 1'b1;
            break;
          end
          pushBit(1'b0);
        end
      end
    end
    pushBit(1'b0);
  endtask

  task automatic applyStimulus(input logic rwv, input logic [6:0] addr, input logic [1:0] nb,
                               input logic [31:0] tx, input int nackByte, input logic [31:0] rdData,
                               input bit midStart);
    int busyCycles;
    int s0, p0;
    modelTransaction(rwv, addr, nb, tx, nackByte, rdData);
    @(negedge clk);
    cfgNackByte = nackByte;
    cfgRdData   = rdData;
    s0 = startCnt;
    p0 = stopCnt;
    start = 1'b1; rw = rwv; slv_addr = addr; num_bytes = nb; tx_data = tx;
    @(negedge clk);
    start = 1'b0;
    busyCycles = 0;
    while (busy && busyCycles < WAIT_LIMIT) begin
      busyCycles++;
      if (midStart && busyCycles == 100) begin
        start = 1'b1; rw = ~rwv; slv_addr = addr ^ 7'h2A; tx_data = ~tx;
      end
      if (midStart && busyCycles == 102) start = 1'b0;
      @(negedge clk);
    end
    checkOutput("busyWidth", 64'(busyCycles), 64'(CLK_DIV * expQuarters));
    checkOutput("donePulse", 64'(done), 64'd1);
    checkOutput("ackErr", 64'(ack_err), 64'(expErr));
    checkOutput("rxData", 64'(rx_data), 64'(expRx));
    @(negedge clk);
    checkOutput("doneWidth", 64'(done), 64'd0);
    checkOutput("trace", traceBits, expTrace);
    checkOutput("traceLen", 64'(traceLen), 64'(expLen));
    checkOutput("startStop", {startCnt - s0, stopCnt - p0}, {32'd1, 32'd1});
  endtask

  task automatic resetMidWrite();
    int cycles;
    @(negedge clk);
    cfgNackByte = -1;
    start = 1'b1; rw = 1'b0; slv_addr = SLAVE_ADDR; num_bytes = 2'd3; tx_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cycles = 0;
    while (traceLen < 12 && cycles < WAIT_LIMIT) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("rstReachWrByte", 64'(cycles < WAIT_LIMIT), 64'd1);
    reset = 1'b0;
    #1;
    checkOutput("rstMidSCL", 64'(SCL), 64'd1);
    checkOutput("rstMidSDA", 64'((SDA === 1'b0) ? 1'b0 : 1'b1), 64'd1);
    checkOutput("rstMidBusy", 64'(busy), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; rw = 1'b0; slv_addr = 7'd0; num_bytes = 2'd0; tx_data = 32'd0;
    cfgNackByte = -1; cfgRdData = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstSCL", 64'(SCL), 64'd1);
    checkOutput("rstSDA", 64'((SDA === 1'b0) ? 1'b0 : 1'b1), 64'd1);
    checkOutput("rstBusy", 64'(busy), 64'd0);
    checkOutput("rstDone", 64'(done), 64'd0);
    checkOutput("rstAckErr", 64'(ack_err), 64'd0);
    checkOutput("rstRxData", 64'(rx_data), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(1'b0, SLAVE_ADDR, 2'd3, 32'h015A0000, -1, 32'd0, 1'b0);
    applyStimulus(1'b0, SLAVE_ADDR, 2'd3, 32'h11123441, -1, 32'd0, 1'b0);
    applyStimulus(1'b0, SLAVE_ADDR, 2'd0, 32'hA1000000, -1, 32'd0, 1'b0);
    applyStimulus(1'b1, SLAVE_ADDR, 2'd3, 32'd0, -1, 32'h12344100, 1'b0);
    applyStimulus(1'b0, 7'h23, 2'd1, 32'hDEADBEEF, -1, 32'd0, 1'b0);
    applyStimulus(1'b1, SLAVE_ADDR, 2'd0, 32'd0, -1, 32'hC3A5A5A5, 1'b0);
    applyStimulus(1'b0, SLAVE_ADDR, 2'd2, 32'h12345678, 1, 32'd0, 1'b0);
    applyStimulus(1'b0, SLAVE_ADDR, 2'd2, 32'hCAFEF00D, -1, 32'd0, 1'b1);
    resetMidWrite();
    applyStimulus(1'b1, SLAVE_ADDR, 2'd1, 32'd0, -1, 32'h9E3779B9, 1'b0);

    for (int n = 0; n < 24; n++) begin
      rndRw   = 1'($urandom_range(0, 1));
      rndAddr = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : SLAVE_ADDR;
      rndNb   = 2'($urandom_range(0, 3));
      rndNack = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, int'(rndNb))) : -1;
      applyStimulus(rndRw, rndAddr, rndNb, $urandom, rndNack, $urandom, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
